// File: rtl/input_stage_mc_if.sv
// input_stage_mc_if: per-channel control and configuration bus between the
// timer register block (master) and the capture front-end (slave).
interface input_stage_mc_if #(
  parameter int CH_NUM = 4,
  parameter int FILT_W = 4
);
  logic [CH_NUM-1:0]        ctrl_active_i;
  logic [CH_NUM-1:0]        ctrl_update_i;
  logic [CH_NUM-1:0]        ctrl_arm_i;
  logic [CH_NUM-1:0]        cnt_end_i;
  logic [CH_NUM*8-1:0]      cfg_sel_i;
  logic [CH_NUM*3-1:0]      cfg_mode_i;
  logic [CH_NUM-1:0]        cfg_sel_clk_i;
  logic [CH_NUM*FILT_W-1:0] cfg_filt_i;

  modport master (
    output ctrl_active_i, ctrl_update_i, ctrl_arm_i, cnt_end_i,
    output cfg_sel_i, cfg_mode_i, cfg_sel_clk_i, cfg_filt_i
  );

  modport slave (
    input ctrl_active_i, ctrl_update_i, ctrl_arm_i, cnt_end_i,
    input cfg_sel_i, cfg_mode_i, cfg_sel_clk_i, cfg_filt_i
  );
endinterface

// File: rtl/input_stage_mc.sv
// input_stage_mc: multi-channel capture front-end for the advanced timer.
// Shared synchronisers feed CH_NUM channels, each with its own signal select,
// optional stability filter and event generator.
// Optional feature: define INPUT_STAGE_MC_FILTER_EN to build the filter
// counters; without it every channel behaves as threshold N = 0.

module input_stage_mc_ch #(
  parameter int EXTSIG_NUM = 32,
  parameter int FILT_W     = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [EXTSIG_NUM-1:0] i_sync,
  input  logic                  i_ls_rise,
  input  logic                  i_active,
  input  logic                  i_update,
  input  logic                  i_arm,
  input  logic                  i_cnt_end,
  input  logic [7:0]            i_sel,
  input  logic [2:0]            i_mode,
  input  logic                  i_sel_clk,
  input  logic [FILT_W-1:0]     i_filt,
  output logic                  o_event,
  output logic                  o_level
);
  // Out-of-range selects read as a constant 0.
  function automatic logic pick(input logic [EXTSIG_NUM-1:0] v, input logic [7:0] s);
    logic b;
    b = 1'b0;
    for (int i = 0; i < EXTSIG_NUM; i++)
      if (s == 8'(i)) b = v[i];
    return b;
  endfunction

  logic [7:0] r_sel;
  logic [2:0] r_mode;
  logic       r_sel_clk, r_level, r_event, r_armed, r_latch;
  logic       w_raw, w_raw_new, w_q, w_take, w_flip, w_nl;
  logic       w_rise, w_fall, w_edge, w_func;

  assign w_raw     = pick(i_sync, r_sel);
  assign w_raw_new = pick(i_sync, i_sel);
  assign w_q       = r_sel_clk ? i_ls_rise : 1'b1;
  // An update cycle owns the channel: no filtering, no event.
  assign w_take    = i_active & w_q & ~i_update;

`ifdef INPUT_STAGE_MC_FILTER_EN
  logic [FILT_W-1:0] r_filt_n, r_cnt;
  assign w_flip = (w_raw != r_level) && (r_cnt == r_filt_n);

  // Stability counter: any sample matching the current level restarts it.
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      r_filt_n <= '0;
      r_cnt    <= '0;
    end else if (i_update) begin
      r_filt_n <= i_filt;
      r_cnt    <= '0;
    end else if (w_take) begin
      r_cnt <= ((w_raw == r_level) || w_flip) ? '0 : r_cnt + 1'b1;
    end
`else
  logic w_filt_unused;
  assign w_filt_unused = ^i_filt;
  assign w_flip        = (w_raw != r_level);
`endif

  assign w_nl   = w_flip ? w_raw : r_level;
  assign w_rise = ~r_level & w_nl;
  assign w_fall = r_level & ~w_nl;

  // Event function per mode; w_edge is the edge that sets the armed latch.
  always_comb begin
    w_edge = 1'b0;
    w_func = 1'b0;
    case (r_mode)
      3'd0: w_func = 1'b1;
      3'd1: w_func = ~w_nl;
      3'd2: w_func = w_nl;
      3'd3: w_func = w_rise;
      3'd4: w_func = w_fall;
      3'd5: w_func = w_rise | w_fall;
      3'd6: begin w_edge = w_rise; w_func = r_armed & (r_latch | w_rise); end
      3'd7: begin w_edge = w_fall; w_func = r_armed & (r_latch | w_fall); end
    endcase
  end

  // Shadow config and filtered level; level reloads straight from the new source.
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      r_sel     <= '0;
      r_mode    <= '0;
      r_sel_clk <= 1'b0;
      r_level   <= 1'b0;
    end else if (i_update) begin
      r_sel     <= i_sel;
      r_mode    <= i_mode;
      r_sel_clk <= i_sel_clk;
      r_level   <= w_raw_new;
    end else if (w_take) begin
      r_level <= w_nl;
    end

  // Registered event pulse, only on qualified active samples.
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) r_event <= 1'b0;
    else         r_event <= w_take & w_func;

  // Arm/latch: arm beats counter end; counter end beats a latching edge.
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      r_armed <= 1'b0;
      r_latch <= 1'b0;
    end else begin
      if (i_arm)          r_armed <= 1'b1;
      else if (i_cnt_end) r_armed <= 1'b0;
      if (i_cnt_end)                       r_latch <= 1'b0;
      else if (w_take & r_armed & w_edge)  r_latch <= 1'b1;
    end

  assign o_event = r_event;
  assign o_level = r_level;
endmodule

module input_stage_mc #(
  parameter int CH_NUM     = 4,
  parameter int EXTSIG_NUM = 32,
  parameter int FILT_W     = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input_stage_mc_if.slave       ctrl,
  input  logic                  ls_clk_i,
  input  logic [EXTSIG_NUM-1:0] signal_i,
  output logic [CH_NUM-1:0]     event_o,
  output logic [CH_NUM-1:0]     level_o
);
  logic [EXTSIG_NUM-1:0] r_sig_s1, r_sig_s2;
  logic [2:0]            r_ls_s;
  logic                  w_ls_rise;

  // Shared synchronisers: 2 flops per signal, 3 for the slow clock edge detect.
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      r_sig_s1 <= '0;
      r_sig_s2 <= '0;
      r_ls_s   <= '0;
    end else begin
      r_sig_s1 <= signal_i;
      r_sig_s2 <= r_sig_s1;
      r_ls_s   <= {r_ls_s[1:0], ls_clk_i};
    end

  assign w_ls_rise = r_ls_s[1] & ~r_ls_s[2];

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    input_stage_mc_ch #(.EXTSIG_NUM(EXTSIG_NUM), .FILT_W(FILT_W)) u_ch (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .i_sync    (r_sig_s2),
      .i_ls_rise (w_ls_rise),
      .i_active  (ctrl.ctrl_active_i[c]),
      .i_update  (ctrl.ctrl_update_i[c]),
      .i_arm     (ctrl.ctrl_arm_i[c]),
      .i_cnt_end (ctrl.cnt_end_i[c]),
      .i_sel     (ctrl.cfg_sel_i[8*c +: 8]),
      .i_mode    (ctrl.cfg_mode_i[3*c +: 3]),
      .i_sel_clk (ctrl.cfg_sel_clk_i[c]),
      .i_filt    (ctrl.cfg_filt_i[FILT_W*c +: FILT_W]),
      .o_event   (event_o[c]),
      .o_level   (level_o[c])
    );
  end
endmodule

// File: tb/tb_input_stage_mc.sv
// tb_input_stage_mc: directed stimulus with a cycle-stamped expectation queue;
// a negedge monitor pops entries at their cycle and flags any unexpected event.
module tb_input_stage_mc;
  logic        clk = 1'b0;
  logic        rstn;
  logic        ls_clk;
  logic [31:0] sig;
  logic [3:0]  ev, lvl;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    int       cyc;
    logic [3:0] ev;
    logic [3:0] lmask;
    logic [3:0] lvl;
    string    name;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  input_stage_mc_if #(.CH_NUM(4), .FILT_W(4)) bus();

  input_stage_mc #(.CH_NUM(4), .EXTSIG_NUM(32), .FILT_W(4)) dut (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .ctrl     (bus),
    .ls_clk_i (ls_clk),
    .signal_i (sig),
    .event_o  (ev),
    .level_o  (lvl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare scheduled expectations, otherwise demand a quiet event bus.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      mon_e = sbq.pop_front();
      tests++; fails++;
      $display("FAIL %s: expectation for cycle %0d never checked", mon_e.name, mon_e.cyc);
    end
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      mon_e = sbq.pop_front();
      tests++;
      if (ev !== mon_e.ev || (lvl & mon_e.lmask) !== (mon_e.lvl & mon_e.lmask)) begin
        fails++;
        $display("FAIL %s @%0d: event_o=%b level_o=%b, expected event_o=%b level_o=%b (mask %b)",
                 mon_e.name, cyc, ev, lvl, mon_e.ev, mon_e.lvl, mon_e.lmask);
      end
    end else if (ev !== 4'b0000) begin
      tests++; fails++;
      $display("FAIL unexpected_event @%0d: event_o=%b, expected 0000", cyc, ev);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int off, input logic [3:0] e, input logic [3:0] m,
                      input logic [3:0] l, input string nm);
    exp_t x;
    x.cyc = cyc + off; x.ev = e; x.lmask = m; x.lvl = l; x.name = nm;
    sbq.push_back(x);
  endtask

  task automatic cfg(input int c, input logic [7:0] sel, input logic [2:0] mode,
                     input logic sc, input logic [3:0] n);
    bus.cfg_sel_i[8*c +: 8]  = sel;
    bus.cfg_mode_i[3*c +: 3] = mode;
    bus.cfg_sel_clk_i[c]     = sc;
    bus.cfg_filt_i[4*c +: 4] = n;
    bus.ctrl_update_i[c]     = 1'b1;
    step(1);
    bus.ctrl_update_i[c]     = 1'b0;
  endtask

  initial begin
    bus.ctrl_active_i = '0; bus.ctrl_update_i = '0; bus.ctrl_arm_i = '0;
    bus.cnt_end_i = '0; bus.cfg_sel_i = '0; bus.cfg_mode_i = '0;
    bus.cfg_sel_clk_i = '0; bus.cfg_filt_i = '0;
    sig = '0; ls_clk = 1'b0; rstn = 1'b0;

    step(3); push(0, 4'b0000, 4'hF, 4'b0000, "reset_state");
    step(1); rstn = 1'b1; step(3);

    // Ch0 rise detect, N=0: pulse 3 cycles after the drive cycle
    cfg(0, 8'd5, 3'd3, 1'b0, 4'd0); bus.ctrl_active_i[0] = 1'b1; step(2);
    sig[5] = 1'b1;
    push(3, 4'b0001, 4'b0001, 4'b0001, "t1_rise_pulse");
    push(5, 4'b0000, 4'b0001, 4'b0001, "t1_level_hold");
    step(8);
    sig[5] = 1'b0; push(3, 4'b0000, 4'b0001, 4'b0000, "t1_fall_no_event");
    step(6); bus.ctrl_active_i[0] = 1'b0;

    // Ch1 filter N=3, mode 5: 3-cycle glitch then 4-cycle pulse
    cfg(1, 8'd7, 3'd5, 1'b0, 4'd3); bus.ctrl_active_i[1] = 1'b1; step(2);
    sig[7] = 1'b1;
`ifdef INPUT_STAGE_MC_FILTER_EN
    push(4, 4'b0000, 4'b0010, 4'b0000, "t2_glitch_level");
    push(6, 4'b0000, 4'b0010, 4'b0000, "t2_glitch_level_end");
`else
    push(3, 4'b0010, 4'b0010, 4'b0010, "t2_glitch_rise");
    push(6, 4'b0010, 4'b0010, 4'b0000, "t2_glitch_fall");
`endif
    step(3); sig[7] = 1'b0; step(6);
    sig[7] = 1'b1;
`ifdef INPUT_STAGE_MC_FILTER_EN
    push(6,  4'b0010, 4'b0010, 4'b0010, "t2_pulse_rise");
    push(10, 4'b0010, 4'b0010, 4'b0000, "t2_pulse_fall");
`else
    push(3, 4'b0010, 4'b0010, 4'b0010, "t2_pulse_rise");
    push(7, 4'b0010, 4'b0010, 4'b0000, "t2_pulse_fall");
`endif
    step(4); sig[7] = 1'b0; step(10); bus.ctrl_active_i[1] = 1'b0;

    // Ch2 level mode on slow-clock rising edges, input held high
    sig[9] = 1'b1; step(3);
    cfg(2, 8'd9, 3'd2, 1'b1, 4'd0); bus.ctrl_active_i[2] = 1'b1; step(2);
    for (int k = 0; k < 3; k++) begin
      ls_clk = 1'b1; push(3, 4'b0100, 4'b0100, 4'b0100, "t3_ls_pulse");
      step(5); ls_clk = 1'b0; step(5);
    end
    step(3); bus.ctrl_active_i[2] = 1'b0;

    // Ch3 armed rise latch
    cfg(3, 8'd11, 3'd6, 1'b0, 4'd0); bus.ctrl_active_i[3] = 1'b1; step(2);
    sig[11] = 1'b1; step(5); sig[11] = 1'b0; step(5);
    bus.ctrl_arm_i[3] = 1'b1; step(1); bus.ctrl_arm_i[3] = 1'b0; step(1);
    sig[11] = 1'b1;
    for (int k = 3; k <= 7; k++) push(k, 4'b1000, 4'b1000, 4'b1000, "t4_latched");
    step(6);
    // arm and counter end together: stays armed, latch cleared
    bus.ctrl_arm_i[3] = 1'b1; bus.cnt_end_i[3] = 1'b1; step(1);
    bus.ctrl_arm_i[3] = 1'b0; bus.cnt_end_i[3] = 1'b0; step(4);
    sig[11] = 1'b0; step(5);
    sig[11] = 1'b1;
    for (int k = 3; k <= 6; k++) push(k, 4'b1000, 4'b1000, 4'b1000, "t4_rearmed");
    step(5); bus.cnt_end_i[3] = 1'b1; step(1); bus.cnt_end_i[3] = 1'b0; step(4);
    bus.ctrl_active_i[3] = 1'b0;

    // Ch0 out-of-range select, then update to a high input
    cfg(0, 8'd40, 3'd5, 1'b0, 4'd0); bus.ctrl_active_i[0] = 1'b1; step(2);
    push(1, 4'b0000, 4'b0001, 4'b0000, "t5_oob_level");
    sig = '1;
    push(5, 4'b0000, 4'b0001, 4'b0000, "t5_oob_hold");
    step(6);
    push(1, 4'b0000, 4'b0001, 4'b0001, "t5_update_level");
    cfg(0, 8'd5, 3'd5, 1'b0, 4'd0);
    step(3); bus.ctrl_active_i[0] = 1'b0; sig = '0; step(4);

    // All channels concurrently, distinct modes and sels
    cfg(0, 8'd1, 3'd3, 1'b0, 4'd0); cfg(1, 8'd2, 3'd4, 1'b0, 4'd0);
    cfg(2, 8'd3, 3'd5, 1'b0, 4'd0); cfg(3, 8'd4, 3'd7, 1'b0, 4'd0);
    bus.ctrl_arm_i[3] = 1'b1; step(1); bus.ctrl_arm_i[3] = 1'b0;
    bus.ctrl_active_i = 4'hF; step(2);
    sig[4:1] = 4'hF;
    push(3, 4'b0101, 4'hF, 4'b1111, "t6_rise");
    push(5, 4'b1010, 4'hF, 4'b0101, "t6_fall_ch1_ch3");
    push(6, 4'b1000, 4'hF, 4'b0101, "t6_latch_ch3");
    push(7, 4'b1100, 4'hF, 4'b0001, "t6_fall_ch2");
    push(8, 4'b1000, 4'hF, 4'b0001, "t6_cnt_end_cycle");
    push(9, 4'b0000, 4'hF, 4'b0001, "t6_disarmed");
    step(2); sig[2] = 1'b0; sig[4] = 1'b0;
    step(2); sig[3] = 1'b0;
    step(3); bus.cnt_end_i[3] = 1'b1; step(1); bus.cnt_end_i[3] = 1'b0; step(4);

    // Reset while the ch0 filter is counting
    cfg(0, 8'd1, 3'd3, 1'b0, 4'd5);
    sig[1] = 1'b0; sig[2] = 1'b1;
`ifdef INPUT_STAGE_MC_FILTER_EN
    push(3, 4'b0000, 4'b0011, 4'b0011, "t7_counting");
`else
    push(3, 4'b0000, 4'b0011, 4'b0010, "t7_counting");
`endif
    step(4); rstn = 1'b0;
    push(0, 4'b0000, 4'hF, 4'b0000, "t7_reset_mid_count");
    step(2); bus.ctrl_active_i = '0; step(1); rstn = 1'b1;
    push(2, 4'b0000, 4'hF, 4'b0000, "t7_after_reset");
    step(10);

    if (sbq.size() != 0) begin
      tests += sbq.size(); fails += sbq.size();
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
